// File: rtl/clock_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment clock display.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package clock_display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

    localparam logic [2:0] DIG_H1 = 3'd5;
    localparam logic [2:0] DIG_H0 = 3'd4;
    localparam logic [2:0] DIG_M1 = 3'd3;
    localparam logic [2:0] DIG_M0 = 3'd2;
    localparam logic [2:0] DIG_S1 = 3'd1;
    localparam logic [2:0] DIG_S0 = 3'd0;

    typedef enum logic {
        VISIBLE = 1'b0,
        DARK    = 1'b1
    } blink_state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 light only segment g (a dash) to flag a bad digit.
module bcd_to_7seg
    import clock_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output seg_t       o_seg
);

    // Map each BCD code to its segment pattern
    always_comb begin
        o_seg = SEG_DASH;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed display scanner for HH.MM.SS with per-frame
// snapshots, ghost blanking, separator dots and alarm blinking.
module clock_display_scan
    import clock_display_pkg::*;
#(
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [3:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic [3:0] S_in1,
    input  logic [3:0] S_in0,
    input  logic       Alarm,
    output logic [5:0] an,
    output seg_t       seg,
    output logic       dp
);

    localparam logic [7:0] PRE_MAX = 8'(SCAN_DIV - 1);
    localparam logic [3:0] BC_MAX  = 4'(BLINK_FRAMES - 1);

    logic [7:0]      r_pre;
    logic [2:0]      r_idx;
    logic [5:0][3:0] r_snap;
    logic [3:0]      r_bcnt;
    blink_state_t    r_state;

    logic [3:0]      w_bcnt_next;
    blink_state_t    w_state_next;
    logic            w_tick;
    logic            w_wrap;
    logic [3:0]      w_digit;
    seg_t            w_seg;
    logic            w_blank;
    logic [5:0]      w_an_lit;
    logic            w_sep;

    assign w_tick   = (r_pre == PRE_MAX);
    assign w_wrap   = w_tick && (r_idx == DIG_S0);
    assign w_digit  = r_snap[r_idx];
    assign w_blank  = (r_pre == 8'd0) || ((r_state == DARK) && Alarm);
    assign w_an_lit = ~(6'b000001 << r_idx);
    assign w_sep    = (r_idx == DIG_H0) || (r_idx == DIG_M0);

    bcd_to_7seg u_dec (
        .i_bcd (w_digit),
        .o_seg (w_seg)
    );

    // Prescaler: divides the clock down to one tick per digit slot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_pre <= '0;
        else       r_pre <= w_tick ? 8'd0 : r_pre + 8'd1;
    end

    // Digit index walks leftmost to rightmost, one slot per tick
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_idx <= DIG_H1;
        else if (w_tick) r_idx <= (r_idx == DIG_S0) ? DIG_H1 : r_idx - 3'd1;
    end

    // Latch a coherent time value at the end of every frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_snap <= '0;
        else if (w_wrap) r_snap <= {{2'b00, H_in1}, H_in0, M_in1, M_in0, S_in1, S_in0};
    end

    // Blink FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= VISIBLE;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_bcnt  <= w_bcnt_next;
        end
    end

    // Blink FSM: count frames while ringing, flip phase every BLINK_FRAMES
    always_comb begin
        w_state_next = r_state;
        w_bcnt_next  = r_bcnt;
        if (!Alarm) begin
            w_state_next = VISIBLE;
            w_bcnt_next  = '0;
        end else if (w_wrap) begin
            if (r_bcnt == BC_MAX) begin
                w_bcnt_next = '0;
                unique case (r_state)
                    VISIBLE: w_state_next = DARK;
                    DARK:    w_state_next = VISIBLE;
                endcase
            end else begin
                w_bcnt_next = r_bcnt + 4'd1;
            end
        end
    end

    // Registered display outputs, one cycle behind the scan state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an  <= 6'b111111;
            seg <= SEG_OFF;
            dp  <= 1'b1;
        end else begin
            an  <= w_blank ? 6'b111111 : w_an_lit;
            seg <= w_seg;
            dp  <= ~(~w_blank && w_sep);
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: two instances (SCAN_DIV 4 and 2)
// share random stimulus and are checked against a frame-level model.
module tb_clock_display_scan;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
    logic       Alarm;

    logic [5:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;

    int errors = 0;
    int checks = 0;

    logic [13:0] q0[$];
    logic [13:0] q1[$];

    int         k_m[2];
    int         cnt_m[2];
    logic [3:0] dig_m[2][6];

    localparam logic [13:0] RST = {6'b111111, 7'b1111111, 1'b1};

    always #5 clock = ~clock;

    clock_display_scan #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut0 (
        .clock(clock), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm),
        .an(an0), .seg(seg0), .dp(dp0)
    );

    clock_display_scan #(.SCAN_DIV(2), .BLINK_FRAMES(1)) dut1 (
        .clock(clock), .reset(reset),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .S_in1(S_in1), .S_in0(S_in0), .Alarm(Alarm),
        .an(an1), .seg(seg1), .dp(dp1)
    );

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [13:0] got, input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got an=%b seg=%b dp=%b exp an=%b seg=%b dp=%b",
                     nm, $time, got[13:8], got[7:1], got[0], exp[13:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic int m_idx(input int u, input int d);
        return 5 - ((k_m[u] / d) % 6);
    endfunction

    // Frame-level model: position from cycle count, digits latched per frame
    task automatic model(input int u, input int d, input int bf, output logic [13:0] e);
        int         pre, idx;
        bit         dark, wrap;
        logic [5:0] a;
        logic [6:0] s;
        logic       p;
        pre  = k_m[u] % d;
        idx  = m_idx(u, d);
        dark = Alarm && (((cnt_m[u] / bf) % 2) == 1);
        a    = (pre == 0 || dark) ? 6'b111111 : ~(6'd1 << idx);
        s    = pat(dig_m[u][idx]);
        p    = (a != 6'b111111 && (idx == 4 || idx == 2)) ? 1'b0 : 1'b1;
        e    = {a, s, p};
        wrap = (k_m[u] % (6 * d)) == (6 * d - 1);
        if (wrap) begin
            dig_m[u][5] = {2'b00, H_in1};
            dig_m[u][4] = H_in0;
            dig_m[u][3] = M_in1;
            dig_m[u][2] = M_in0;
            dig_m[u][1] = S_in1;
            dig_m[u][0] = S_in0;
        end
        if (!Alarm)    cnt_m[u] = 0;
        else if (wrap) cnt_m[u]++;
        k_m[u]++;
    endtask

    task automatic tick_push();
        logic [13:0] e;
        if (reset) begin
            for (int u = 0; u < 2; u++) begin
                k_m[u]   = 0;
                cnt_m[u] = 0;
                for (int j = 0; j < 6; j++) dig_m[u][j] = 4'd0;
            end
            q0.push_back(RST);
            q1.push_back(RST);
        end else begin
            model(0, 4, 2, e);
            q0.push_back(e);
            model(1, 2, 1, e);
            q1.push_back(e);
        end
    endtask

    task automatic step();
        tick_push();
        @(negedge clock);
    endtask

    task automatic rnd_inputs(input int prob);
        if ($urandom_range(0, prob - 1) == 0) begin
            case ($urandom_range(0, 5))
                0: H_in1 = 2'($urandom_range(0, 3));
                1: H_in0 = 4'($urandom_range(0, 15));
                2: M_in1 = 4'($urandom_range(0, 15));
                3: M_in0 = 4'($urandom_range(0, 15));
                4: S_in1 = 4'($urandom_range(0, 15));
                default: S_in0 = 4'($urandom_range(0, 15));
            endcase
        end
    endtask

    // Monitor: every output cycle pops one expectation per instance
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q0.size() > 0) chk("div4", {an0, seg0, dp0}, q0.pop_front());
            if (q1.size() > 0) chk("div2", {an1, seg1, dp1}, q1.pop_front());
        end
    end

    initial begin
        int n;
        H_in1 = 2'd1; H_in0 = 4'd2;
        M_in1 = 4'd3; M_in0 = 4'd4;
        S_in1 = 4'd5; S_in0 = 4'd6;
        Alarm = 1'b0;
        @(negedge clock);
        repeat (3) step();
        reset = 1'b0;
        repeat (72) step();

        S_in0 = 4'd5;
        n = 0;
        while (!(m_idx(0, 4) == 3 && k_m[0] % 4 == 1) && n < 100) begin
            step();
            n++;
        end
        S_in0 = 4'd6;
        repeat (60) step();

        M_in1 = 4'hC;
        repeat (50) step();

        repeat (600) begin
            rnd_inputs(20);
            step();
        end

        Alarm = 1'b1;
        repeat (500) begin
            rnd_inputs(30);
            step();
        end

        n = 0;
        while (!(((cnt_m[0] / 2) % 2) == 1 && k_m[0] % 4 == 2) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL dark_wait got n=%0d exp <300", n);
        end
        Alarm = 1'b0;
        repeat (50) step();

        repeat (800) begin
            rnd_inputs(25);
            if ($urandom_range(0, 59) == 0) Alarm = ~Alarm;
            step();
        end
        Alarm = 1'b0;

        n = 0;
        while (!(m_idx(0, 4) == 2 && k_m[0] % 4 == 2) && n < 100) begin
            step();
            n++;
        end
        reset = 1'b1;
        #1;
        chk("async_rst0", {an0, seg0, dp0}, RST);
        chk("async_rst1", {an1, seg1, dp1}, RST);
        repeat (2) step();
        reset = 1'b0;
        repeat (100) begin
            rnd_inputs(20);
            step();
        end

        repeat (2) @(posedge clock);
        #2;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL drain got q0=%0d q1=%0d exp 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
